// File: rtl/kv_queue_pkg.sv
// Shared types and constants for the key/value write-coalescing queue.
package kv_queue_pkg;

    localparam int KEY_W_DEF   = 64;
    localparam int VALUE_W_DEF = 128;

    localparam logic [31:0] DROP_CNT_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [KEY_W_DEF-1:0]   key;
        logic [VALUE_W_DEF-1:0] value;
    } kv_entry_t;

endpackage

// File: rtl/kv_key_match.sv
// One-hot match of a single key against every valid queue entry.
module kv_key_match
    import kv_queue_pkg::*;
#(
    parameter int KEY_WIDTH = KEY_W_DEF,
    parameter int DEPTH     = 8
) (
    input  logic [KEY_WIDTH-1:0]            key,
    input  logic [DEPTH-1:0][KEY_WIDTH-1:0] keys,
    input  logic [DEPTH-1:0]                valid,
    output logic [DEPTH-1:0]                match
);

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (keys[i] == key);
        end
    end

endmodule

// File: rtl/kv_write_queue.sv
// Two-port write-coalescing queue: merges writes to pending keys, drops on overflow,
// and streams pending writes out in arrival order.
module kv_write_queue
    import kv_queue_pkg::*;
#(
    parameter int KEY_WIDTH   = 64,
    parameter int VALUE_WIDTH = 128,
    parameter int DEPTH       = 8,
    parameter int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [KEY_WIDTH-1:0]   wa1_i,
    input  logic [VALUE_WIDTH-1:0] wd1_i,
    input  logic                   we1_i,
    input  logic [KEY_WIDTH-1:0]   wa2_i,
    input  logic [VALUE_WIDTH-1:0] wd2_i,
    input  logic                   we2_i,
    output logic                   out_valid_o,
    output logic [KEY_WIDTH-1:0]   out_key_o,
    output logic [VALUE_WIDTH-1:0] out_value_o,
    input  logic                   out_ready_i,
    output logic [CNT_WIDTH-1:0]   count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [31:0]            drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int FW    = CNT_WIDTH + 1;

    logic [DEPTH-1:0][KEY_WIDTH-1:0]   key_q;
    logic [DEPTH-1:0][VALUE_WIDTH-1:0] value_q;
    logic [DEPTH-1:0]                  valid_q;
    logic [PTR_W-1:0]                  rd_ptr, wr_ptr, wr2_ptr;
    logic [CNT_WIDTH-1:0]              count_q;
    logic [31:0]                       drop_q;

    logic                pop, we1_eff;
    logic [DEPTH-1:0]    match1, match2, head_oh, hit1, hit2;
    logic                merge1, merge2, need1, need2, push1, push2;
    logic [FW-1:0]       free;
    logic [1:0]          drops;
    logic [32:0]         drop_sum;
    logic [31:0]         drop_next;

    kv_key_match #(.KEY_WIDTH(KEY_WIDTH), .DEPTH(DEPTH)) u_match1 (
        .key   (wa1_i),
        .keys  (key_q),
        .valid (valid_q),
        .match (match1)
    );

    kv_key_match #(.KEY_WIDTH(KEY_WIDTH), .DEPTH(DEPTH)) u_match2 (
        .key   (wa2_i),
        .keys  (key_q),
        .valid (valid_q),
        .match (match2)
    );

    assign out_valid_o = valid_q[rd_ptr];
    assign out_key_o   = key_q[rd_ptr];
    assign out_value_o = value_q[rd_ptr];
    assign count_o     = count_q;
    assign full_o      = (count_q == CNT_WIDTH'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign drop_cnt_o  = drop_q;

    assign pop     = out_valid_o & out_ready_i;
    // Same key on both ports collapses into the port-2 write.
    assign we1_eff = we1_i & ~(we2_i & (wa1_i == wa2_i));
    assign head_oh = DEPTH'(1) << rd_ptr;

    // A head that is leaving this cycle cannot absorb a merge; the write re-enters at the tail.
    assign hit1   = match1 & ~(head_oh & {DEPTH{pop}});
    assign hit2   = match2 & ~(head_oh & {DEPTH{pop}});
    assign merge1 = we1_eff & (|hit1);
    assign merge2 = we2_i & (|hit2);
    assign need1  = we1_eff & ~merge1;
    assign need2  = we2_i & ~merge2;

    assign free    = FW'(DEPTH) - FW'(count_q) + FW'(pop);
    assign push1   = need1 & (free != '0);
    assign push2   = need2 & (free > FW'(push1));
    assign wr2_ptr = wr_ptr + PTR_W'(push1);

    assign drops     = 2'(need1 & ~push1) + 2'(need2 & ~push2);
    assign drop_sum  = {1'b0, drop_q} + 33'(drops);
    assign drop_next = (drop_sum > {1'b0, DROP_CNT_MAX}) ? DROP_CNT_MAX : drop_sum[31:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q   <= '0;
            value_q <= '0;
            valid_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (merge1 && hit1[i]) value_q[i] <= wd1_i;
                if (merge2 && hit2[i]) value_q[i] <= wd2_i;
            end
            // Pushes land in free slots only, so they never collide with a merge target.
            if (push1) begin
                key_q[wr_ptr]   <= wa1_i;
                value_q[wr_ptr] <= wd1_i;
                valid_q[wr_ptr] <= 1'b1;
            end
            if (push2) begin
                key_q[wr2_ptr]   <= wa2_i;
                value_q[wr2_ptr] <= wd2_i;
                valid_q[wr2_ptr] <= 1'b1;
            end
            wr_ptr  <= wr_ptr + PTR_W'(push1) + PTR_W'(push2);
            count_q <= count_q + CNT_WIDTH'(push1) + CNT_WIDTH'(push2) - CNT_WIDTH'(pop);
            drop_q  <= drop_next;
        end
    end

endmodule

// File: tb/tb_kv_write_queue.sv
// Bench for kv_write_queue: directed vector table, reference queue model, randomized traffic, mid-stream reset.
module tb_kv_write_queue;
    import kv_queue_pkg::*;

    localparam int KW    = 64;
    localparam int VW    = 128;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic [KW-1:0] wa1_i = '0, wa2_i = '0;
    logic [VW-1:0] wd1_i = '0, wd2_i = '0;
    logic          we1_i = 1'b0, we2_i = 1'b0, out_ready_i = 1'b0;
    logic          out_valid_o, full_o, empty_o;
    logic [KW-1:0] out_key_o;
    logic [VW-1:0] out_value_o;
    logic [CW-1:0] count_o;
    logic [31:0]   drop_cnt_o;

    always #5 clk_i = ~clk_i;

    kv_write_queue #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wa1_i       (wa1_i),
        .wd1_i       (wd1_i),
        .we1_i       (we1_i),
        .wa2_i       (wa2_i),
        .wd2_i       (wd2_i),
        .we2_i       (we2_i),
        .out_valid_o (out_valid_o),
        .out_key_o   (out_key_o),
        .out_value_o (out_value_o),
        .out_ready_i (out_ready_i),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    int n_vec = 0;
    int n_err = 0;

    kv_entry_t       mq[$];
    longint unsigned mdrop = 0;

    typedef struct {
        logic        we1;
        logic [7:0]  wa1;
        logic [11:0] wd1;
        logic        we2;
        logic [7:0]  wa2;
        logic [11:0] wd2;
        logic        rdy;
        int          cnt;
        int          drop;
        logic        vld;
        logic [7:0]  key;
        logic [11:0] val;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we1, input int wa1, input int wd1,
                                input logic we2, input int wa2, input int wd2, input logic rdy,
                                input int cnt, input int drop, input logic vld,
                                input int key, input int val);
        vec_t v;
        v.we1 = we1; v.wa1 = 8'(wa1); v.wd1 = 12'(wd1);
        v.we2 = we2; v.wa2 = 8'(wa2); v.wd2 = 12'(wd2);
        v.rdy = rdy; v.cnt = cnt; v.drop = drop; v.vld = vld;
        v.key = 8'(key); v.val = 12'(val);
        return v;
    endfunction

    // Reference: ordered list of pending entries, updated from the inputs about to be clocked in.
    task automatic model_step();
        bit        popm, e1, n1, n2, p1, p2;
        int        free, idx1, idx2, drops;
        kv_entry_t t;
        popm = (mq.size() > 0) && out_ready_i;
        free = DEPTH - mq.size() + (popm ? 1 : 0);
        e1   = we1_i && !(we2_i && (wa1_i == wa2_i));
        idx1 = -1;
        idx2 = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (!(i == 0 && popm)) begin
                if (e1 && mq[i].key == wa1_i) idx1 = i;
                if (we2_i && mq[i].key == wa2_i) idx2 = i;
            end
        end
        if (idx1 >= 0) begin t = mq[idx1]; t.value = wd1_i; mq[idx1] = t; end
        if (idx2 >= 0) begin t = mq[idx2]; t.value = wd2_i; mq[idx2] = t; end
        n1 = e1 && (idx1 < 0);
        n2 = we2_i && (idx2 < 0);
        p1 = n1 && (free >= 1);
        p2 = n2 && (free >= (p1 ? 2 : 1));
        drops = ((n1 && !p1) ? 1 : 0) + ((n2 && !p2) ? 1 : 0);
        if (popm) void'(mq.pop_front());
        if (p1) begin t.key = wa1_i; t.value = wd1_i; mq.push_back(t); end
        if (p2) begin t.key = wa2_i; t.value = wd2_i; mq.push_back(t); end
        mdrop = mdrop + longint'(drops);
        if (mdrop > 64'hFFFF_FFFF) mdrop = 64'hFFFF_FFFF;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, out_valid_o, mq.size() > 0);
        if (mq.size() > 0) begin
            chk({tag, "_key"}, out_key_o, mq[0].key);
            chk({tag, "_value"}, out_value_o, mq[0].value);
        end
        chk({tag, "_count"}, count_o, mq.size());
        chk({tag, "_full"}, full_o, mq.size() == DEPTH);
        chk({tag, "_empty"}, empty_o, mq.size() == 0);
        chk({tag, "_drop"}, drop_cnt_o, mdrop);
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk_i);
        #1;
        check_model(tag);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, out_valid_o, 1'b0);
        chk({tag, "_key"}, out_key_o, '0);
        chk({tag, "_value"}, out_value_o, '0);
        chk({tag, "_count"}, count_o, '0);
        chk({tag, "_full"}, full_o, 1'b0);
        chk({tag, "_empty"}, empty_o, 1'b1);
        chk({tag, "_drop"}, drop_cnt_o, '0);
    endtask

    task automatic drive_idle();
        we1_i = 1'b0; we2_i = 1'b0; out_ready_i = 1'b0;
        wa1_i = '0; wa2_i = '0; wd1_i = '0; wd2_i = '0;
    endtask

    initial begin
        // single push, pop
        tbl.push_back(mk(1, 'h10, 'hA, 0, 0, 0, 0,   1, 0, 1, 'h10, 'hA));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,        0, 0, 0, 0, 0));
        // merge
        tbl.push_back(mk(1, 'h10, 'h1, 0, 0, 0, 0,   1, 0, 1, 'h10, 'h1));
        tbl.push_back(mk(1, 'h20, 'h2, 0, 0, 0, 0,   2, 0, 1, 'h10, 'h1));
        tbl.push_back(mk(1, 'h10, 'h3, 0, 0, 0, 0,   2, 0, 1, 'h10, 'h3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,        1, 0, 1, 'h20, 'h2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,        0, 0, 0, 0, 0));
        // same-cycle same key
        tbl.push_back(mk(1, 'h5, 'h11, 1, 'h5, 'h22, 0, 1, 0, 1, 'h5, 'h22));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,        0, 0, 0, 0, 0));
        // overflow: keys 0..9, value = 0x100 + key
        tbl.push_back(mk(1, 0, 'h100, 1, 1, 'h101, 0, 2, 0, 1, 0, 'h100));
        tbl.push_back(mk(1, 2, 'h102, 1, 3, 'h103, 0, 4, 0, 1, 0, 'h100));
        tbl.push_back(mk(1, 4, 'h104, 1, 5, 'h105, 0, 6, 0, 1, 0, 'h100));
        tbl.push_back(mk(1, 6, 'h106, 1, 7, 'h107, 0, 8, 0, 1, 0, 'h100));
        tbl.push_back(mk(1, 8, 'h108, 1, 9, 'h109, 0, 8, 2, 1, 0, 'h100));
        // full with simultaneous pop
        tbl.push_back(mk(1, 'h30, 'h300, 1, 'h31, 'h301, 1, 8, 3, 1, 1, 'h101));
        // drain in order
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,        7, 3, 1, 2, 'h102));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,        6, 3, 1, 3, 'h103));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,        5, 3, 1, 4, 'h104));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,        4, 3, 1, 5, 'h105));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,        3, 3, 1, 6, 'h106));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,        2, 3, 1, 7, 'h107));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,        1, 3, 1, 'h30, 'h300));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,        0, 3, 0, 0, 0));
        // head-pop race
        tbl.push_back(mk(1, 'h7, 'h70, 0, 0, 0, 0,   1, 3, 1, 'h7, 'h70));
        tbl.push_back(mk(0, 0, 0, 1, 'h8, 'h80, 0,   2, 3, 1, 'h7, 'h70));
        tbl.push_back(mk(1, 'h7, 'h9, 0, 0, 0, 1,    2, 3, 1, 'h8, 'h80));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,        1, 3, 1, 'h7, 'h9));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,        0, 3, 0, 0, 0));

        #1 rst_ni = 1'b0;
        #2 check_reset("por");
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        check_reset("post_rst");

        foreach (tbl[i]) begin
            we1_i = tbl[i].we1; wa1_i = KW'(tbl[i].wa1); wd1_i = VW'(tbl[i].wd1);
            we2_i = tbl[i].we2; wa2_i = KW'(tbl[i].wa2); wd2_i = VW'(tbl[i].wd2);
            out_ready_i = tbl[i].rdy;
            step($sformatf("m%0d", i));
            chk($sformatf("t%0d_count", i), count_o, tbl[i].cnt);
            chk($sformatf("t%0d_drop", i), drop_cnt_o, tbl[i].drop);
            chk($sformatf("t%0d_valid", i), out_valid_o, tbl[i].vld);
            chk($sformatf("t%0d_full", i), full_o, tbl[i].cnt == DEPTH);
            chk($sformatf("t%0d_empty", i), empty_o, tbl[i].cnt == 0);
            if (tbl[i].vld) begin
                chk($sformatf("t%0d_key", i), out_key_o, KW'(tbl[i].key));
                chk($sformatf("t%0d_value", i), out_value_o, VW'(tbl[i].val));
            end
        end

        // randomized traffic over a small key space to force merges, head races and drops
        for (int c = 0; c < 400; c++) begin
            we1_i = ($urandom_range(0, 3) != 0);
            we2_i = ($urandom_range(0, 3) != 0);
            wa1_i = KW'($urandom_range(0, 11));
            wa2_i = KW'($urandom_range(0, 11));
            wd1_i = {$urandom, $urandom, $urandom, $urandom};
            wd2_i = {$urandom, $urandom, $urandom, $urandom};
            out_ready_i = ($urandom_range(0, 2) == 0);
            step($sformatf("r%0d", c));
        end

        // fill a few entries, then reset between edges
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            we1_i = 1'b1; wa1_i = KW'(100 + 2 * c); wd1_i = VW'(c);
            we2_i = 1'b1; wa2_i = KW'(101 + 2 * c); wd2_i = VW'(c + 10);
            out_ready_i = 1'b1;
            step($sformatf("f%0d", c));
        end
        chk("pre_rst_busy", empty_o, 1'b0);
        #2 rst_ni = 1'b0;
        #1 check_reset("mid_rst");
        mq.delete();
        mdrop = 0;
        drive_idle();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        check_reset("mid_rst_rel");

        for (int c = 0; c < 40; c++) begin
            we1_i = ($urandom_range(0, 1) != 0);
            we2_i = ($urandom_range(0, 1) != 0);
            wa1_i = KW'($urandom_range(0, 9));
            wa2_i = KW'($urandom_range(0, 9));
            wd1_i = VW'($urandom);
            wd2_i = VW'($urandom);
            out_ready_i = ($urandom_range(0, 3) == 0);
            step($sformatf("a%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kv_write_queue.md
# kv_write_queue

Two-port write-coalescing queue that sits directly downstream of the random write generator. Each cycle it accepts up to two key/value write requests, merges requests whose key is already pending, and presents the pending writes one at a time, in arrival order, on a valid/ready stream to the key-value store model. The generator has no backpressure, so overflow is handled by dropping writes and counting them.

## Interface
- KEY_WIDTH, 64, key width in bits
- VALUE_WIDTH, 128, value width in bits
- DEPTH, 8, number of queue entries; power of two, >= 2
- CNT_WIDTH, $clog2(DEPTH)+1, width of the occupancy count

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- wa1_i  in  KEY_WIDTH  port-1 write key
- wd1_i  in  VALUE_WIDTH  port-1 write value
- we1_i  in  1  port-1 write enable
- wa2_i  in  KEY_WIDTH  port-2 write key
- wd2_i  in  VALUE_WIDTH  port-2 write value
- we2_i  in  1  port-2 write enable
- out_valid_o  out  1  head entry available
- out_key_o  out  KEY_WIDTH  head key
- out_value_o  out  VALUE_WIDTH  head value
- out_ready_i  in  1  consumer accepts head
- count_o  out  CNT_WIDTH  entries occupied
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0
- drop_cnt_o  out  32  dropped writes, saturating

## Operation
- Storage is a circular buffer of {key, value, valid} entries. rd_ptr and wr_ptr wrap modulo DEPTH.
- pop = out_valid_o & out_ready_i. The head is removed at the clock edge.
- Same-cycle same-key rule: if we1_i & we2_i and wa1_i == wa2_i, the pair is treated as a single port-2 write, so wd2_i wins.
- Merge: an enabled write whose key matches a valid entry overwrites that entry's value in place. The entry keeps its queue position and no new entry is allocated.
- Exception: a match against the head while pop is asserted is not a merge. The write is pushed as a new entry so the update is not lost.
- Keys are unique among valid entries at all times.
- Non-merged writes are pushed at the tail. Port 1 is pushed before port 2.
- Capacity: free = DEPTH - count + pop.
  - Port 1 has priority for free slots.
  - Each write that finds no free slot is dropped, and drop_cnt_o increments by 1 per drop (+2 when both ports drop).
  - drop_cnt_o saturates at 32'hFFFF_FFFF.
- count_o next = count + pushes - pop.
- Reset values:
  - out_valid_o = 0
  - out_key_o = 0
  - out_value_o = 0
  - count_o = 0
  - full_o = 0
  - empty_o = 1
  - drop_cnt_o = 0
  - all valid bits = 0
  - both pointers = 0
- Reset asserted mid-operation discards all entries immediately, regardless of any handshake in progress.

## Timing
- All outputs are driven from registers. The head fields come from the entry at rd_ptr, read from the register array.
- Latency: a write presented at edge N into an empty queue appears on out_* after edge N, with out_valid_o = 1 in cycle N+1.
- A merge into a non-head entry becomes visible when that entry reaches the head.
- A merge into the head while not popping updates out_value_o in the next cycle.
- out_key_o and out_value_o hold stable while out_valid_o = 1 and out_ready_i = 0, except for the head-merge value update above.
- out_ready_i may be asserted while out_valid_o = 0. It has no effect in that case.
- Pop and push can occur in the same cycle. When full, a pop frees one slot for that cycle's writes.
- Throughput: one pop per cycle, up to two pushes per cycle.

## Structure
- Package kv_queue_pkg:
  - typedef kv_entry_t = struct {key, value}, parameterised by the package defaults 64/128.
  - constant DROP_CNT_MAX.
- Sub-module kv_key_match: combinational one-hot match vector of one key against the DEPTH valid entries. Instantiate it twice, once per port.
- Everything else (pointers, count, drop counter, push/merge decode) lives in kv_write_queue.

## Test plan
- Single push: reset, then we1_i = 1, wa1_i = 0x10, wd1_i = 0xA for one cycle with out_ready_i = 0 -> next cycle out_valid_o = 1, out_key_o = 0x10, out_value_o = 0xA, count_o = 1, empty_o = 0.
- Merge: push key 0x10/value 0x1, then key 0x20/value 0x2, then key 0x10/value 0x3 -> count_o = 2; pops yield (0x10, 0x3) then (0x20, 0x2).
- Same-cycle same key: we1_i = we2_i = 1, both keys 0x5, wd1_i = 0x11, wd2_i = 0x22 -> count_o = 1, head value 0x22.
- Overflow: DEPTH = 8, out_ready_i = 0, push distinct keys 0..9 two per cycle -> count_o = 8, full_o = 1, drop_cnt_o = 2, queue holds keys 0..7 in order.
- Full with simultaneous pop: full queue, out_ready_i = 1, two new distinct keys -> one pushed, one dropped, count_o stays 8, drop_cnt_o += 1.
- Head-pop race and reset: head key 0x7 popping while we1_i writes key 0x7/value 0x9 -> new tail entry (0x7, 0x9). Assert rst_ni low mid-stream -> outputs return to reset values and drop_cnt_o = 0.
